traffic_timer_sensor: RTL and testbench
=======================================

Name: traffic_timer_sensor

Overview:
Companion block that drives the CAR and TIMEOUT inputs of the traffic light controller. It watches the controller's GRN/YLW/RED lamp outputs. It conditions a raw, asynchronous vehicle-loop sensor into a debounced CAR request, gated by a minimum-green interval. It also times the red phase and issues a one-cycle TIMEOUT pulse. A sticky FAULT output flags any illegal (non-one-hot) lamp combination.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive sampled cycles a synchronized sensor level must hold before the debounced value changes (>=1)
MIN_GREEN_CYCLES, 8, sampled GRN cycles required before CAR may assert (>=1)
RED_CYCLES, 16, sampled RED cycles before TIMEOUT pulses (>=1)
CNT_W, 8, width of all internal counters; every count parameter must be <= 2^CNT_W-1

Ports:
CLK  input  1  single system clock, rising edge
RESET_N  input  1  asynchronous, active-low reset
CAR_RAW  input  1  raw loop-detector level, asynchronous to CLK
GRN  input  1  green lamp from controller (same clock domain)
YLW  input  1  yellow lamp from controller
RED  input  1  red lamp from controller
CAR  output  1  registered vehicle request to controller
TIMEOUT  output  1  registered one-cycle red-expiry pulse
FAULT  output  1  registered sticky illegal-lamp flag

Behaviour:
- Reset (RESET_N=0, async): CAR=0, TIMEOUT=0, FAULT=0; sync flops=0; debounced car=0; all counters=0; monitor state=S_GREEN.
- Sensor path: 2-flop synchronizer on CAR_RAW. The debounce counter counts consecutive cycles where the synced value differs from the debounced value and resets to 0 when they agree. When the counter reaches DEBOUNCE_CYCLES, the debounced value flips and the counter clears.
- Lamp sampling: GRN/YLW/RED are sampled directly each edge, with no synchronizer.
- Monitor FSM states: S_GREEN, S_YELLOW, S_RED, S_RED_DONE, S_FAULT.
  - Any state except S_FAULT, sampled lamps not one-hot -> S_FAULT.
  - Sampled GRN: entered from another state -> S_GREEN with green_cnt=1; staying in S_GREEN -> green_cnt increments, saturating at MIN_GREEN_CYCLES.
  - Sampled YLW -> S_YELLOW; green_cnt and red_cnt clear.
  - Sampled RED from S_GREEN/S_YELLOW -> S_RED with red_cnt=1.
  - In S_RED, sampled RED -> red_cnt increments. On the edge where red_cnt becomes RED_CYCLES: TIMEOUT<=1 for exactly that one cycle, state -> S_RED_DONE.
  - S_RED_DONE: TIMEOUT=0; holds until lamps leave RED. No second pulse, however long RED persists.
  - S_FAULT: absorbing until reset. FAULT=1; CAR and TIMEOUT forced 0.
- CAR (registered): 1 when next state is S_GREEN, next green_cnt >= MIN_GREEN_CYCLES and next debounced car=1. Otherwise 0, so it clears on the first edge that samples YLW.
- Closed-loop timing with the controller:
  - RED lamp lasts exactly RED_CYCLES+1 clock cycles.
  - GREEN lasts at least MIN_GREEN_CYCLES+1 cycles.
  - Sensor-to-CAR latency is 2 (sync) + DEBOUNCE_CYCLES cycles, minimum.
- Boundary conditions:
  - Lamps leave RED before expiry: red_cnt clears, no TIMEOUT.
  - Sensor bounce shorter than DEBOUNCE_CYCLES: no change on CAR.
  - Debounced car drops mid-green: CAR drops on the same edge.
  - All lamps 0 counts as not one-hot and is a fault.
  - Counters never wrap; all saturate or clear.
  - Reset asserted mid-red: TIMEOUT drops immediately and the red count is lost.

Decomposition:
- Package traffic_pkg: monitor state enum (S_GREEN..S_FAULT, 3-bit encoding) and default count constants shared with the controller's testbench.
- One sub-module: car_debouncer, covering the synchronizer plus debounce counter, parameterized by DEBOUNCE_CYCLES and CNT_W, with a single debounced-level output.

Test Plan:
- Reset with RESET_N=0 mid-cycle, lamps GRN -> CAR=0, TIMEOUT=0, FAULT=0 asynchronously; after release with CAR_RAW=0 for 50 cycles, CAR stays 0.
- Closed loop with defaults, CAR_RAW held 1 from reset -> CAR rises after green_cnt reaches 8, YLW 1 cycle, RED exactly 17 cycles, TIMEOUT high exactly 1 cycle; repeat 3 rounds.
- CAR_RAW glitches of 1, 2 and 3 cycles during established green -> CAR never asserts; 4-cycle pulse -> CAR asserts 6 cycles after the rising edge.
- Open-loop RED held 40 cycles -> exactly one TIMEOUT pulse, at sampled-RED cycle 16; RED dropped after 10 cycles, then reasserted -> count restarts, pulse 16 cycles after reassertion.
- Force GRN=1 and RED=1 for one cycle -> FAULT=1 the next cycle and stays 1; CAR/TIMEOUT held 0 despite stimulus until RESET_N pulse.
- Parameter sweep DEBOUNCE_CYCLES=1, MIN_GREEN_CYCLES=1, RED_CYCLES=1 -> RED lasts 2 cycles, CAR latency 3 cycles, no counter overflow.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and default timing constants for the traffic lamp monitor and its controller bench.
// Pure definitions; no logic.
package traffic_pkg;

  typedef enum logic [2:0] {
    S_GREEN    = 3'd0,
    S_YELLOW   = 3'd1,
    S_RED      = 3'd2,
    S_RED_DONE = 3'd3,
    S_FAULT    = 3'd4
  } mon_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES  = 4;
  localparam int unsigned DEF_MIN_GREEN_CYCLES = 8;
  localparam int unsigned DEF_RED_CYCLES       = 16;
  localparam int unsigned DEF_CNT_W            = 8;

  function automatic logic lamps_onehot(input logic grn, input logic ylw, input logic red);
    return (grn & ~ylw & ~red) | (~grn & ylw & ~red) | (~grn & ~ylw & red);
  endfunction

endpackage

// File: rtl/car_debouncer.sv
// Two-flop synchronizer plus consecutive-mismatch debounce on the raw loop sensor.
// Output is the debounced level as it will be after the coming edge, so a registered consumer sees it with no extra delay.
module car_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic car_raw_i,
  output logic car_deb_o
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == DEB_LAST) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= car_raw_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign car_deb_o = deb_d;

endmodule

// File: rtl/traffic_timer_sensor.sv
// Lamp monitor that generates CAR (debounced, min-green gated) and a one-cycle red-expiry TIMEOUT.
// Outputs are registered one edge after the lamp/sensor sample; any non-one-hot lamp set latches FAULT until reset.
module traffic_timer_sensor
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned MIN_GREEN_CYCLES = DEF_MIN_GREEN_CYCLES,
  parameter int unsigned RED_CYCLES       = DEF_RED_CYCLES,
  parameter int unsigned CNT_W            = DEF_CNT_W
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic CAR_RAW,
  input  logic GRN,
  input  logic YLW,
  input  logic RED,
  output logic CAR,
  output logic TIMEOUT,
  output logic FAULT
);

  localparam logic [CNT_W-1:0] MIN_G   = CNT_W'(MIN_GREEN_CYCLES);
  localparam logic [CNT_W-1:0] RED_LIM = CNT_W'(RED_CYCLES);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] green_cnt_q, green_cnt_d;
  logic [CNT_W-1:0] red_cnt_q, red_cnt_d;
  logic             car_q, car_d;
  logic             timeout_q, timeout_d;
  logic             fault_q, fault_d;
  logic             car_deb;

  car_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debouncer (
    .clk_i    (CLK),
    .rst_ni   (RESET_N),
    .car_raw_i(CAR_RAW),
    .car_deb_o(car_deb)
  );

  always_comb begin
    state_d     = state_q;
    green_cnt_d = green_cnt_q;
    red_cnt_d   = red_cnt_q;
    timeout_d   = 1'b0;
    if (state_q != S_FAULT) begin
      if (!lamps_onehot(GRN, YLW, RED)) begin
        state_d = S_FAULT;
      end else if (GRN) begin
        state_d   = S_GREEN;
        red_cnt_d = '0;
        if (state_q != S_GREEN) begin
          green_cnt_d = ONE;
        end else if (green_cnt_q < MIN_G) begin
          green_cnt_d = green_cnt_q + 1'b1;
        end
      end else if (YLW) begin
        state_d     = S_YELLOW;
        green_cnt_d = '0;
        red_cnt_d   = '0;
      end else begin
        green_cnt_d = '0;
        // S_RED_DONE keeps its count frozen so a long red never pulses twice
        if (state_q != S_RED_DONE) begin
          red_cnt_d = (state_q == S_RED) ? red_cnt_q + 1'b1 : ONE;
          if (red_cnt_d == RED_LIM) begin
            state_d   = S_RED_DONE;
            timeout_d = 1'b1;
          end else begin
            state_d = S_RED;
          end
        end
      end
    end
    fault_d = (state_d == S_FAULT);
    car_d   = (state_d == S_GREEN) && (green_cnt_d >= MIN_G) && car_deb;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_GREEN;
      green_cnt_q <= '0;
      red_cnt_q   <= '0;
      car_q       <= 1'b0;
      timeout_q   <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      green_cnt_q <= green_cnt_d;
      red_cnt_q   <= red_cnt_d;
      car_q       <= car_d;
      timeout_q   <= timeout_d;
      fault_q     <= fault_d;
    end
  end

  assign CAR     = car_q;
  assign TIMEOUT = timeout_q;
  assign FAULT   = fault_q;

endmodule

// File: tb/tb_traffic_timer_sensor.sv
// Bench: two instances (default timing, and all counts = 1) against a run-length/history model plus directed literal checks.
module tb_traffic_timer_sensor;

  logic       CLK     = 1'b0;
  logic       RESET_N = 1'b0;
  logic [1:0] raw     = 2'b00;
  logic [1:0] g       = 2'b11;
  logic [1:0] y       = 2'b00;
  logic [1:0] r       = 2'b00;
  logic [1:0] car, tmo, flt;

  int n_vec = 0;
  int n_err = 0;

  // model state per instance
  logic [1:0]  m_r1, m_r2, m_deb, m_flt, exp_car, exp_to;
  logic [15:0] m_sh [2];
  int          m_grun [2];
  int          m_rrun [2];

  // closed-loop controller and measurement
  logic [1:0] closed = 2'b00;
  logic [1:0] car_prev = 2'b00;
  logic [1:0] to_prev = 2'b00;
  logic [2:0] prev_lc [2];
  logic [2:0] lc;
  int run_len [2];
  int pulses [2];
  int greens [2];
  int reds [2];
  int la, lb, ca, cb, fa, fb;
  logic seen_a, seen_b;

  traffic_timer_sensor #(
    .DEBOUNCE_CYCLES(4), .MIN_GREEN_CYCLES(8), .RED_CYCLES(16), .CNT_W(8)
  ) dut_a (
    .CLK(CLK), .RESET_N(RESET_N), .CAR_RAW(raw[0]), .GRN(g[0]), .YLW(y[0]), .RED(r[0]),
    .CAR(car[0]), .TIMEOUT(tmo[0]), .FAULT(flt[0])
  );

  traffic_timer_sensor #(
    .DEBOUNCE_CYCLES(1), .MIN_GREEN_CYCLES(1), .RED_CYCLES(1), .CNT_W(8)
  ) dut_b (
    .CLK(CLK), .RESET_N(RESET_N), .CAR_RAW(raw[1]), .GRN(g[1]), .YLW(y[1]), .RED(r[1]),
    .CAR(car[1]), .TIMEOUT(tmo[1]), .FAULT(flt[1])
  );

  initial forever #5 CLK = ~CLK;

  function automatic int debp(input int i);  return (i == 0) ? 4 : 1;  endfunction
  function automatic int mingp(input int i); return (i == 0) ? 8 : 1;  endfunction
  function automatic int redp(input int i);  return (i == 0) ? 16 : 1; endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_r1 = '0; m_r2 = '0; m_deb = '0; m_flt = '0; exp_car = '0; exp_to = '0;
    for (int i = 0; i < 2; i++) begin
      m_sh[i] = '0; m_grun[i] = 0; m_rrun[i] = 0;
    end
  endtask

  // Spec-level rules: CAR needs a debounced car and a long-enough green run;
  // TIMEOUT fires on the sample where the red run length equals RED_CYCLES.
  task automatic model_edge();
    logic [15:0] mask;
    if (!RESET_N) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_sh[i] = {m_sh[i][14:0], m_r2[i]};
        m_r2[i] = m_r1[i];
        m_r1[i] = raw[i];
        mask = (16'd1 << debp(i)) - 16'd1;
        if (m_deb[i] ? ((m_sh[i] & mask) == 16'd0) : ((m_sh[i] & mask) == mask))
          m_deb[i] = ~m_deb[i];
        if ((int'(g[i]) + int'(y[i]) + int'(r[i])) != 1) m_flt[i] = 1'b1;
        m_grun[i] = g[i] ? ((m_grun[i] < 1000) ? m_grun[i] + 1 : 1000) : 0;
        m_rrun[i] = r[i] ? ((m_rrun[i] < 1000) ? m_rrun[i] + 1 : 1000) : 0;
        exp_car[i] = !m_flt[i] && (m_grun[i] >= mingp(i)) && m_deb[i];
        exp_to[i]  = !m_flt[i] && (m_rrun[i] == redp(i));
      end
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      check_bit($sformatf("car[%0d]", i), car[i], exp_car[i]);
      check_bit($sformatf("timeout[%0d]", i), tmo[i], exp_to[i]);
      check_bit($sformatf("fault[%0d]", i), flt[i], m_flt[i]);
      if (closed[i]) begin
        if (g[i] && car_prev[i]) begin
          g[i] = 1'b0; y[i] = 1'b1;
        end else if (y[i]) begin
          y[i] = 1'b0; r[i] = 1'b1;
        end else if (r[i] && to_prev[i]) begin
          r[i] = 1'b0; g[i] = 1'b1;
        end
      end
    end
    car_prev = car;
    to_prev  = tmo;
  endtask

  task automatic set_lamps(input logic [2:0] gyr);
    g = {2{gyr[2]}}; y = {2{gyr[1]}}; r = {2{gyr[0]}};
  endtask

  task automatic pulse(input int len, output int lat_a, output int lat_b);
    lat_a = 0; lat_b = 0;
    raw = 2'b11;
    for (int k = 1; k <= 14; k++) begin
      if (k == len + 1) raw = 2'b00;
      cyc();
      if (lat_a == 0 && car[0]) lat_a = k;
      if (lat_b == 0 && car[1]) lat_b = k;
    end
    raw = 2'b00;
    repeat (10) cyc();
  endtask

  task automatic red_run(input int n, output int cnt_a, output int cnt_b,
                         output int first_a, output int first_b);
    cnt_a = 0; cnt_b = 0; first_a = 0; first_b = 0;
    set_lamps(3'b010);
    cyc();
    set_lamps(3'b001);
    for (int k = 1; k <= n; k++) begin
      cyc();
      if (tmo[0]) begin cnt_a++; if (first_a == 0) first_a = k; end
      if (tmo[1]) begin cnt_b++; if (first_b == 0) first_b = k; end
    end
  endtask

  task automatic reset_pulse();
    RESET_N = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      check_bit($sformatf("async_rst_car[%0d]", i), car[i], 1'b0);
      check_bit($sformatf("async_rst_timeout[%0d]", i), tmo[i], 1'b0);
      check_bit($sformatf("async_rst_fault[%0d]", i), flt[i], 1'b0);
    end
    #1 RESET_N = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    for (int i = 0; i < 2; i++) begin
      check_bit($sformatf("por_car[%0d]", i), car[i], 1'b0);
      check_bit($sformatf("por_fault[%0d]", i), flt[i], 1'b0);
    end
    cyc();
    RESET_N = 1'b1;

    // idle green with no vehicle: CAR must stay low
    seen_a = 1'b0;
    repeat (50) begin cyc(); if (car != 2'b00) seen_a = 1'b1; end
    check_bit("idle_no_car", seen_a, 1'b0);

    // closed loop with a waiting vehicle
    closed = 2'b11;
    raw    = 2'b11;
    for (int i = 0; i < 2; i++) begin
      prev_lc[i] = {g[i], y[i], r[i]}; run_len[i] = 1; pulses[i] = 0; greens[i] = 0; reds[i] = 0;
    end
    for (int c = 0; c < 140; c++) begin
      cyc();
      for (int i = 0; i < 2; i++) begin
        lc = {g[i], y[i], r[i]};
        if (lc != prev_lc[i]) begin
          case (prev_lc[i])
            3'b001: begin
              check_int($sformatf("red_len[%0d]", i), run_len[i], redp(i) + 1);
              check_int($sformatf("red_pulses[%0d]", i), pulses[i], 1);
              reds[i]++;
              pulses[i] = 0;
            end
            3'b010: check_int($sformatf("ylw_len[%0d]", i), run_len[i], 1);
            3'b100: begin
              if (greens[i] > 0) check_int($sformatf("grn_len[%0d]", i), run_len[i], mingp(i) + 1);
              greens[i]++;
            end
            default: ;
          endcase
          prev_lc[i] = lc;
          run_len[i] = 1;
        end else begin
          run_len[i]++;
        end
        if (tmo[i]) pulses[i]++;
      end
    end
    check_int("rounds_a_ge3", (reds[0] >= 3) ? 1 : 0, 1);
    check_int("rounds_b_ge3", (reds[1] >= 3) ? 1 : 0, 1);
    closed = 2'b00;

    // established green, sensor idle, then glitches and a real pulse
    set_lamps(3'b100);
    raw = 2'b00;
    repeat (20) cyc();
    for (int len = 1; len <= 4; len++) begin
      pulse(len, la, lb);
      check_int($sformatf("car_latency_a_len%0d", len), la, (len == 4) ? 6 : 0);
      check_int($sformatf("car_latency_b_len%0d", len), lb, 3);
    end

    // open-loop red timing
    red_run(40, ca, cb, fa, fb);
    check_int("red40_pulses_a", ca, 1);
    check_int("red40_at_a", fa, 16);
    check_int("red40_pulses_b", cb, 1);
    check_int("red40_at_b", fb, 1);
    red_run(10, ca, cb, fa, fb);
    check_int("red10_pulses_a", ca, 0);
    check_int("red10_pulses_b", cb, 1);
    red_run(30, ca, cb, fa, fb);
    check_int("red_restart_at_a", fa, 16);
    check_int("red_restart_pulses_a", ca, 1);

    // reset while TIMEOUT is high, red continues afterwards
    set_lamps(3'b010);
    cyc();
    set_lamps(3'b001);
    fa = 0;
    for (int k = 1; k <= 40 && fa == 0; k++) begin
      cyc();
      if (tmo[0]) fa = k;
    end
    check_int("pre_reset_pulse_at", fa, 16);
    reset_pulse();
    fa = 0;
    for (int k = 1; k <= 30; k++) begin
      cyc();
      if (fa == 0 && tmo[0]) fa = k;
    end
    check_int("post_reset_pulse_at", fa, 16);

    // illegal GRN+RED, then stimulus that would otherwise drive CAR and TIMEOUT
    set_lamps(3'b101);
    cyc();
    check_bit("fault_a_set", flt[0], 1'b1);
    check_bit("fault_b_set", flt[1], 1'b1);
    seen_a = 1'b0;
    seen_b = 1'b0;
    set_lamps(3'b100);
    raw = 2'b11;
    repeat (30) begin cyc(); if (car != 2'b00) seen_a = 1'b1; end
    set_lamps(3'b001);
    repeat (25) begin cyc(); if (tmo != 2'b00) seen_b = 1'b1; end
    check_bit("fault_blocks_car", seen_a, 1'b0);
    check_bit("fault_blocks_timeout", seen_b, 1'b0);
    check_bit("fault_a_sticky", flt[0], 1'b1);
    reset_pulse();
    set_lamps(3'b100);
    raw = 2'b00;
    repeat (3) cyc();
    set_lamps(3'b000);
    cyc();
    check_bit("dark_fault_a", flt[0], 1'b1);
    check_bit("dark_fault_b", flt[1], 1'b1);
    set_lamps(3'b100);
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
